// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, runs one req/ack memory access at a time,
// buffers the returned word for decode and absorbs redirects, including mid-request ones.
module fetch_sequencer #(
    parameter int                 ADDR_W   = 64,
    parameter int                 INST_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] pc4,
    output logic [31:0]       fetch_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;
    logic              valid_q, valid_d;
    logic [31:0]       count_q, count_d;
    logic [ADDR_W-1:0] redir_tgt;

    assign redir_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        pc4_d     = pc4_q;
        valid_d   = valid_q;
        count_d   = count_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                if (redirect_valid) begin
                    pc_d   = redir_tgt;
                    addr_d = redir_tgt;
                end else begin
                    addr_d = pc_q;
                end
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    pc_d = redir_tgt;
                    // An unacked request must still complete; its data is dropped in FLUSH.
                    if (imem_ack) begin
                        addr_d  = redir_tgt;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_FLUSH;
                    end
                end else if (imem_ack) begin
                    inst_d    = imem_rdata;
                    inst_pc_d = addr_q;
                    pc4_d     = addr_q + FOUR;
                    valid_d   = 1'b1;
                    pc_d      = addr_q + FOUR;
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (redirect_valid) begin
                    valid_d = 1'b0;
                    pc_d    = redir_tgt;
                    addr_d  = redir_tgt;
                    state_d = S_FETCH;
                end else if (inst_ready) begin
                    valid_d = 1'b0;
                    count_d = count_q + 32'd1;
                    addr_d  = pc_q;
                    state_d = S_FETCH;
                end
            end
            S_FLUSH: begin
                if (redirect_valid) begin
                    pc_d = redir_tgt;
                    if (imem_ack) begin
                        addr_d  = redir_tgt;
                        state_d = S_FETCH;
                    end
                end else if (imem_ack) begin
                    addr_d  = pc_q;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
            pc4_q     <= '0;
            valid_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            pc4_q     <= pc4_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
        end
    end

    assign imem_req    = (state_q == S_FETCH) || (state_q == S_FLUSH);
    assign imem_addr   = addr_q;
    assign inst_valid  = valid_q;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign pc4         = pc4_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run checked
// against a stream-level model of which PC decode should receive next.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic [63:0] pc4;
    logic [31:0] fetch_count;

    logic        w_req;
    logic [63:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_redir;
    logic [63:0] w_redir_pc;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_inst;
    logic [63:0] w_inst_pc;
    logic [63:0] w_pc4;
    logic [31:0] w_count;

    int checks;
    int failures;

    function automatic logic [31:0] f(input logic [63:0] a);
        return a[31:0] ^ {a[63:34], 2'b11} ^ 32'h5A3C_0F01;
    endfunction

    assign imem_rdata = f(imem_addr);
    assign w_rdata    = f(w_addr);
    assign w_ack      = 1'b1;
    assign w_ready    = 1'b1;
    assign w_redir    = 1'b0;
    assign w_redir_pc = 64'h0;

    fetch_sequencer #(.ADDR_W(64), .INST_W(32), .RESET_PC(64'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .pc4(pc4),
        .fetch_count(fetch_count)
    );

    fetch_sequencer #(.ADDR_W(64), .INST_W(32),
                      .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata),
        .redirect_valid(w_redir), .redirect_pc(w_redir_pc),
        .inst_valid(w_valid), .inst_ready(w_ready),
        .inst(w_inst), .inst_pc(w_inst_pc), .pc4(w_pc4),
        .fetch_count(w_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_ack = 1'b0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({imem_req, inst_valid, inst, inst_pc, pc4, fetch_count, imem_addr} !== 258'h0) begin
            failures++;
            $display("FAIL reset_vals req=%b v=%b inst=%h pc=%h pc4=%h cnt=%0d addr=%h want all 0",
                     imem_req, inst_valid, inst, inst_pc, pc4, fetch_count, imem_addr);
        end
        cyc();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
            failures++;
            $display("FAIL first_req req=%b addr=%h want 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_steady();
        do_reset();
        imem_ack = 1'b1;
        inst_ready = 1'b1;
        cyc();
        for (int k = 0; k < 4; k++) begin
            cyc();
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 64'(4*k) || pc4 !== 64'(4*k+4)
                || inst !== f(64'(4*k))) begin
                failures++;
                $display("FAIL steady_%0d v=%b pc=%h pc4=%h inst=%h want 1 %h %h %h",
                         k, inst_valid, inst_pc, pc4, inst, 64'(4*k), 64'(4*k+4), f(64'(4*k)));
            end
            cyc();
            checks++;
            if (inst_valid !== 1'b0) begin
                failures++;
                $display("FAIL steady_gap_%0d v=%b want 0", k, inst_valid);
            end
        end
        checks++;
        if (fetch_count !== 32'd4 || imem_addr !== 64'd16) begin
            failures++;
            $display("FAIL steady_cnt cnt=%0d addr=%h want 4 10", fetch_count, imem_addr);
        end
    endtask

    task automatic test_backpressure();
        inst_ready = 1'b0;
        cyc();
        repeat (5) begin
            cyc();
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 64'd16 || inst !== f(64'd16)
                || imem_req !== 1'b0 || fetch_count !== 32'd4) begin
                failures++;
                $display("FAIL bp_hold v=%b pc=%h inst=%h req=%b cnt=%0d want 1 10 %h 0 4",
                         inst_valid, inst_pc, inst, imem_req, fetch_count, f(64'd16));
            end
        end
        inst_ready = 1'b1;
        cyc();
        checks++;
        if (imem_addr !== 64'd20 || fetch_count !== 32'd5 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release addr=%h cnt=%0d v=%b want 14 5 0",
                     imem_addr, fetch_count, inst_valid);
        end
    endtask

    task automatic test_redirect_outstanding();
        do_reset();
        inst_ready = 1'b1;
        cyc();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 64'h1003;
        cyc();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h0 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_hold req=%b addr=%h v=%b want 1 0 0", imem_req, imem_addr, inst_valid);
        end
        cyc();
        imem_ack = 1'b1;
        checks++;
        if (imem_addr !== 64'h0 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_ack_cycle addr=%h v=%b want 0 0", imem_addr, inst_valid);
        end
        cyc();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h1000 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_next req=%b addr=%h v=%b want 1 1000 0", imem_req, imem_addr, inst_valid);
        end
        cyc();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h1000 || pc4 !== 64'h1004) begin
            failures++;
            $display("FAIL flush_deliver v=%b pc=%h pc4=%h want 1 1000 1004", inst_valid, inst_pc, pc4);
        end
    endtask

    task automatic test_redirect_ack();
        cyc();
        checks++;
        if (imem_addr !== 64'h1004 || fetch_count !== 32'd1) begin
            failures++;
            $display("FAIL redir_pre addr=%h cnt=%0d want 1004 1", imem_addr, fetch_count);
        end
        redirect_valid = 1'b1;
        redirect_pc = 64'h2002;
        cyc();
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h2000) begin
            failures++;
            $display("FAIL redir_ack v=%b req=%b addr=%h want 0 1 2000", inst_valid, imem_req, imem_addr);
        end
        cyc();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h2000) begin
            failures++;
            $display("FAIL redir_ack_deliver v=%b pc=%h want 1 2000", inst_valid, inst_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc = 64'h3000;
        cyc();
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || fetch_count !== 32'd1 || imem_addr !== 64'h3000) begin
            failures++;
            $display("FAIL redir_drain v=%b cnt=%0d addr=%h want 0 1 3000", inst_valid, fetch_count, imem_addr);
        end
        cyc();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h3000) begin
            failures++;
            $display("FAIL redir_drain_next v=%b pc=%h want 1 3000", inst_valid, inst_pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        cyc();
        cyc();
        checks++;
        if (w_valid !== 1'b1 || w_inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC || w_pc4 !== 64'h0) begin
            failures++;
            $display("FAIL wrap_first v=%b pc=%h pc4=%h want 1 fffffffffffffffc 0", w_valid, w_inst_pc, w_pc4);
        end
        cyc();
        checks++;
        if (w_addr !== 64'h0 || w_req !== 1'b1) begin
            failures++;
            $display("FAIL wrap_addr addr=%h req=%b want 0 1", w_addr, w_req);
        end
        cyc();
        checks++;
        if (w_valid !== 1'b1 || w_inst_pc !== 64'h0 || w_pc4 !== 64'h4 || w_count !== 32'd1) begin
            failures++;
            $display("FAIL wrap_second v=%b pc=%h pc4=%h cnt=%0d want 1 0 4 1", w_valid, w_inst_pc, w_pc4, w_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 64'h4000;
        cyc();
        redirect_valid = 1'b0;
        rst = 1'b1;
        cyc();
        checks++;
        if ({imem_req, inst_valid, inst, inst_pc, pc4, fetch_count, imem_addr} !== 258'h0) begin
            failures++;
            $display("FAIL rst_flush req=%b v=%b inst=%h pc=%h pc4=%h cnt=%0d addr=%h want all 0",
                     imem_req, inst_valid, inst, inst_pc, pc4, fetch_count, imem_addr);
        end
        rst = 1'b0;
        imem_ack = 1'b1;
        inst_ready = 1'b0;
        cyc();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h0 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_flush_req req=%b addr=%h v=%b want 1 0 0", imem_req, imem_addr, inst_valid);
        end
        cyc();
        rst = 1'b1;
        cyc();
        checks++;
        if ({imem_req, inst_valid, inst, inst_pc, pc4, fetch_count, imem_addr} !== 258'h0) begin
            failures++;
            $display("FAIL rst_drain req=%b v=%b inst=%h pc=%h pc4=%h cnt=%0d addr=%h want all 0",
                     imem_req, inst_valid, inst, inst_pc, pc4, fetch_count, imem_addr);
        end
        rst = 1'b0;
        cyc();
        cyc();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h0 || inst !== f(64'h0)) begin
            failures++;
            $display("FAIL rst_drain_first v=%b pc=%h inst=%h want 1 0 %h", inst_valid, inst_pc, inst, f(64'h0));
        end
    endtask

    task automatic test_random();
        logic [63:0] exp_next;
        logic [31:0] exp_cnt;
        logic        prev_hold;
        logic [31:0] prev_inst;
        logic [63:0] prev_pc;
        int          delivered;
        logic        deliver;
        do_reset();
        exp_next = 64'h0;
        exp_cnt = 32'h0;
        prev_hold = 1'b0;
        prev_inst = '0;
        prev_pc = '0;
        delivered = 0;
        for (int i = 0; i < 600; i++) begin
            if (prev_hold) begin
                checks++;
                if (inst !== prev_inst || inst_pc !== prev_pc) begin
                    failures++;
                    $display("FAIL rand_hold i=%0d inst=%h pc=%h want %h %h", i, inst, inst_pc, prev_inst, prev_pc);
                end
            end
            checks++;
            if (fetch_count !== exp_cnt) begin
                failures++;
                $display("FAIL rand_cnt i=%0d cnt=%0d want %0d", i, fetch_count, exp_cnt);
            end
            imem_ack = imem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
            inst_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc = {$urandom, $urandom};
            deliver = inst_valid && inst_ready && !redirect_valid;
            if (deliver) begin
                checks++;
                if (inst_pc !== exp_next || pc4 !== exp_next + 64'd4 || inst !== f(exp_next)) begin
                    failures++;
                    $display("FAIL rand_deliver i=%0d pc=%h pc4=%h inst=%h want %h %h %h",
                             i, inst_pc, pc4, inst, exp_next, exp_next + 64'd4, f(exp_next));
                end
                exp_next = exp_next + 64'd4;
                exp_cnt = exp_cnt + 32'd1;
                delivered++;
            end
            if (redirect_valid)
                exp_next = {redirect_pc[63:2], 2'b00};
            prev_hold = inst_valid && !inst_ready && !redirect_valid;
            prev_inst = inst;
            prev_pc = inst_pc;
            cyc();
        end
        redirect_valid = 1'b0;
        checks++;
        if (delivered < 20) begin
            failures++;
            $display("FAIL rand_progress delivered=%0d want >=20", delivered);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        imem_ack = 1'b0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        test_reset();
        test_steady();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_ack();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
